// File: rtl/sub_array_pkg.sv
// Shared types and helpers for the sub-array stream converters.
package sub_array_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSendTop,
    StSendBot
  } state_e;

  // Region select for the index generator.
  localparam logic RegionTop = 1'b0;
  localparam logic RegionBot = 1'b1;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Element counts of the two regions, for a given geometry.
  function automatic int unsigned top_elems(input int unsigned sub_rows, input int unsigned cols);
    return sub_rows * cols;
  endfunction

  function automatic int unsigned bot_elems(input int unsigned rows, input int unsigned sub_rows,
                                            input int unsigned cols);
    return (rows - sub_rows) * cols;
  endfunction

endpackage

// File: rtl/sub_array_index_gen.sv
// Row/col walker for one region: row is the fast (inner) counter wrapping at the region height,
// col is the slow (outer) counter wrapping at COLS.
module sub_array_index_gen
  import sub_array_pkg::*;
#(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned SUB_ROWS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          step,
  input  logic                          clear,
  input  logic                          region,
  output logic [clog2_min1(ROWS)-1:0]   row,
  output logic [clog2_min1(COLS)-1:0]   col,
  output logic                          region_done
);

  localparam int unsigned RowW = clog2_min1(ROWS);
  localparam int unsigned ColW = clog2_min1(COLS);
  // Bottom height of zero only occurs when the bottom region is never entered.
  localparam int unsigned BotRows = (ROWS > SUB_ROWS) ? ROWS - SUB_ROWS : 1;

  logic [RowW-1:0] row_q, row_d, row_max;
  logic [ColW-1:0] col_q, col_d;
  logic            row_wrap, col_wrap;

  // Wrap detection and next counter values; clear wins over step.
  always_comb begin
    row_max  = (region == RegionBot) ? RowW'(BotRows - 1) : RowW'(SUB_ROWS - 1);
    row_wrap = (row_q == row_max);
    col_wrap = (col_q == ColW'(COLS - 1));
    row_d    = row_q;
    col_d    = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (step) begin
      if (row_wrap) begin
        row_d = '0;
        col_d = col_wrap ? '0 : col_q + ColW'(1);
      end else begin
        row_d = row_q + RowW'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row         = row_q;
  assign col         = col_q;
  assign region_done = row_wrap && col_wrap;

endmodule

// File: rtl/convert_3d_sub_array_to_1d_stream.sv
// Serializes a ROWS x COLS frame into single-element beats: top region (rows 0..SUB_ROWS-1)
// column by column, then the bottom region the same way. Frames chain with no bubble when a new
// frame is offered on the last beat.
// Optional feature macro: SUB_ARRAY_STREAM_FRAME_CNT_EN adds a 16-bit completed-frame counter.
module convert_3d_sub_array_to_1d_stream
  import sub_array_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 4,
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned SUB_ROWS  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in [ROWS-1:0][COLS-1:0],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic                 out_last
`ifdef SUB_ARRAY_STREAM_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  localparam int unsigned RowW    = clog2_min1(ROWS);
  localparam int unsigned ColW    = clog2_min1(COLS);
  localparam bit          TopOnly = (SUB_ROWS == ROWS);

  if (SUB_ROWS < 1 || SUB_ROWS > ROWS) begin : g_bad_sub_rows
    $error("SUB_ROWS must lie in 1..ROWS");
  end

  state_e              state_q, state_d;
  logic [BIT_WIDTH-1:0] frame_q [ROWS-1:0][COLS-1:0];
  logic [BIT_WIDTH-1:0] frame_d [ROWS-1:0][COLS-1:0];
  logic                step, clear, region, region_done;
  logic                beat, last_beat, accept;
  logic [RowW-1:0]     row, abs_row;
  logic [ColW-1:0]     col;

  sub_array_index_gen #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SUB_ROWS (SUB_ROWS)
  ) u_index_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .step        (step),
    .clear       (clear),
    .region      (region),
    .row         (row),
    .col         (col),
    .region_done (region_done)
  );

  // Handshakes, next state and counter control.
  always_comb begin
    state_d   = state_q;
    step      = 1'b0;
    clear     = 1'b0;
    region    = (state_q == StSendBot) ? RegionBot : RegionTop;
    out_valid = (state_q != StIdle);
    out_last  = region_done &&
                ((state_q == StSendBot) || ((state_q == StSendTop) && TopOnly));
    beat      = out_valid && out_ready;
    last_beat = beat && out_last;
    in_ready  = rst_n && ((state_q == StIdle) || last_beat);
    accept    = in_valid && in_ready;
    frame_d   = accept ? in : frame_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSendTop;
          clear   = 1'b1;
        end
      end
      StSendTop: begin
        if (beat) begin
          if (region_done) begin
            clear = 1'b1;
            if (TopOnly) state_d = accept ? StSendTop : StIdle;
            else         state_d = StSendBot;
          end else begin
            step = 1'b1;
          end
        end
      end
      StSendBot: begin
        if (beat) begin
          if (region_done) begin
            clear   = 1'b1;
            state_d = accept ? StSendTop : StIdle;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output element mux; bottom rows are offset by the top height.
  always_comb begin
    abs_row  = (region == RegionBot) ? row + RowW'(SUB_ROWS) : row;
    out_data = out_valid ? frame_q[abs_row][col] : '0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Frame register: only loads on accept, so it is frozen for the whole frame.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

`ifdef SUB_ARRAY_STREAM_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Count completed frames, wrapping naturally at 16 bits.
  always_comb begin
    frame_cnt_d = last_beat ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  // Frame counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_convert_3d_sub_array_to_1d_stream.sv
// Randomized scoreboard bench: two DUTs (SUB_ROWS=4 and SUB_ROWS=8) share all inputs and run in
// lockstep; a reference model expands each accepted frame into its expected beat sequence.
module tb_convert_3d_sub_array_to_1d_stream;

  typedef logic [3:0] frame_t [7:0][7:0];
  typedef struct packed {
    logic [3:0] d;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  frame_t     in_arr;
  logic       in_ready_a, out_valid_a, out_last_a;
  logic       in_ready_b, out_valid_b, out_last_b;
  logic [3:0] out_data_a, out_data_b;
`ifdef SUB_ARRAY_STREAM_FRAME_CNT_EN
  logic [15:0] frame_cnt_a, frame_cnt_b;
`endif

  always #5 clk = ~clk;

  convert_3d_sub_array_to_1d_stream #(
    .BIT_WIDTH (4), .ROWS (8), .COLS (8), .SUB_ROWS (4)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in        (in_arr),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_data  (out_data_a),
    .out_last  (out_last_a)
`ifdef SUB_ARRAY_STREAM_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt_a)
`endif
  );

  convert_3d_sub_array_to_1d_stream #(
    .BIT_WIDTH (4), .ROWS (8), .COLS (8), .SUB_ROWS (8)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in        (in_arr),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_data  (out_data_b),
    .out_last  (out_last_b)
`ifdef SUB_ARRAY_STREAM_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt_b)
`endif
  );

  int         checks = 0;
  int         passed = 0;
  exp_t       exp_a[$];
  exp_t       exp_b[$];
  logic [3:0] got_a[$];
  logic [3:0] got_b[$];
  bit         logging = 1'b0;
  bit         stall_mode = 1'b0;
  int         beats_in_frame = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference: top rows then bottom rows, each walked column by column, rows fastest.
  function automatic void model_push(input frame_t f, input int sub, input bit to_b);
    exp_t e;
    int   n;
    int   lo;
    int   hi;
    n = 0;
    for (int reg_i = 0; reg_i < 2; reg_i++) begin
      lo = (reg_i == 0) ? 0 : sub;
      hi = (reg_i == 0) ? sub : 8;
      for (int c = 0; c < 8; c++) begin
        for (int r = lo; r < hi; r++) begin
          n++;
          e.d    = f[r][c];
          e.last = (n == 64);
          if (to_b) exp_b.push_back(e);
          else      exp_a.push_back(e);
        end
      end
    end
  endfunction

  // Monitor / scoreboard, sampling on the falling edge.
  bit         rst_prev = 1'b1;
  bit         prev_accept = 1'b0;
  bit         prev_stall = 1'b0;
  logic [3:0] prev_da, prev_db;
  logic       prev_la, prev_lb;
  exp_t       e;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("in_ready_in_reset", in_ready_a, 0);
      if (!rst_prev) begin
        chk("out_valid_after_reset", out_valid_a, 0);
        chk("out_data_after_reset", out_data_a, 0);
`ifdef SUB_ARRAY_STREAM_FRAME_CNT_EN
        chk("frame_cnt_after_reset", frame_cnt_a, 0);
`endif
      end
      exp_a.delete();
      exp_b.delete();
      beats_in_frame = 0;
      prev_accept = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_accept) chk("valid_one_cycle_after_accept", out_valid_a, 1);
      if (prev_stall) begin
        chk("stall_valid_held", out_valid_a, 1);
        chk("stall_data_a_held", out_data_a, prev_da);
        chk("stall_data_b_held", out_data_b, prev_db);
        chk("stall_last_a_held", out_last_a, prev_la);
        chk("stall_last_b_held", out_last_b, prev_lb);
      end
      chk("in_ready_a", in_ready_a, (!out_valid_a) || (out_ready && out_last_a));
      chk("lockstep_b", {out_valid_b, in_ready_b}, {out_valid_a, in_ready_a});
      if (out_valid_a && out_ready) begin
        if (exp_a.size() == 0) begin
          fail_now("unexpected_beat_a");
        end else begin
          e = exp_a.pop_front();
          chk("data_a", out_data_a, e.d);
          chk("last_a", out_last_a, e.last);
          beats_in_frame = e.last ? 0 : beats_in_frame + 1;
        end
        if (exp_b.size() == 0) begin
          fail_now("unexpected_beat_b");
        end else begin
          e = exp_b.pop_front();
          chk("data_b", out_data_b, e.d);
          chk("last_b", out_last_b, e.last);
        end
        if (logging) begin
          got_a.push_back(out_data_a);
          got_b.push_back(out_data_b);
        end
      end
      prev_accept = in_valid && in_ready_a;
      if (prev_accept) begin
        model_push(in_arr, 4, 1'b0);
        model_push(in_arr, 8, 1'b1);
      end
      prev_stall = out_valid_a && !out_ready;
      prev_da = out_data_a;
      prev_db = out_data_b;
      prev_la = out_last_a;
      prev_lb = out_last_b;
    end
    rst_prev = rst_n;
  end

  // Downstream readiness: always ready, or ~50% random stalls.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_frame(input frame_t f);
    int n;
    in_arr   = f;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready_a && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_a) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_a.size() != 0 || out_valid_a) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_a.size() != 0 || out_valid_a) fail_now("drain_timeout");
  endtask

  task automatic rand_frame(output frame_t f);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) f[r][c] = 4'($urandom_range(0, 15));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  frame_t fill, inv, rf;
  int     n;

  initial begin
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        fill[r][c] = 4'((r * 8 + c) & 15);
        inv[r][c]  = ~fill[r][c];
      end

    // Reset with a frame already offered; it must not be taken until reset releases.
    in_arr   = fill;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full-rate frame with spot checks of the ordering.
    logging = 1'b1;
    send_frame(fill);
    wait_drain();
    logging = 1'b0;
    chk("beats_per_frame", got_a.size(), 64);
    chk("beat0", got_a[0], 4'h0);
    chk("beat1", got_a[1], 4'h8);
    chk("beat4", got_a[4], 4'h1);
    chk("beat32", got_a[32], 4'h0);
    chk("beat63", got_a[63], 4'hF);
    chk("top_only_beat8", got_b[8], 4'h1);
    chk("top_only_beat63", got_b[63], 4'hF);

    // Same frame under random backpressure.
    stall_mode = 1'b1;
    send_frame(fill);
    wait_drain();
    stall_mode = 1'b0;

    // Back-to-back chaining with the inverted frame.
    send_frame(fill);
    send_frame(inv);
    wait_drain();

    // Reset mid-frame, then a fresh frame must start at element [0][0].
    rand_frame(rf);
    send_frame(rf);
    n = 0;
    while (beats_in_frame < 20 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (beats_in_frame < 20) fail_now("beat20_timeout");
    do_reset();
    got_a.delete();
    logging = 1'b1;
    rand_frame(rf);
    send_frame(rf);
    wait_drain();
    logging = 1'b0;
    chk("post_reset_beat0", got_a[0], rf[0][0]);

    // Two more random frames with stalls.
    stall_mode = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rand_frame(rf);
      send_frame(rf);
    end
    wait_drain();
    stall_mode = 1'b0;
`ifdef SUB_ARRAY_STREAM_FRAME_CNT_EN
    chk("frame_cnt_a_three", frame_cnt_a, 3);
    chk("frame_cnt_b_three", frame_cnt_b, 3);
`endif
    chk("queue_a_empty", exp_a.size(), 0);
    chk("queue_b_empty", exp_b.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
